req_rr_encoder: RTL and testbench
=================================

Name: req_rr_encoder

Overview:
- Sequential front-end for the team's one-hot-to-binary encoders.
- Captures up to N request lines into a pending register and serves them one at a time with a round-robin priority pointer.
- Presents each winner as a binary code on a valid/ready output interface.
- Sits between raw request/interrupt sources and any downstream consumer of an encoded index.

Parameters:
- N, 8, number of request lines; power of two, minimum 2.
- CODE_W, $clog2(N) = 3, width of the output code; derived, not overridden.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  capture enable; when 0, req is ignored.
- req  input  N  request lines, sampled every clk edge while en=1.
- ready_i  input  1  downstream accepts code_o when valid_o=1.
- code_o  output  CODE_W  binary index of the granted request.
- valid_o  output  1  code_o holds a granted request.
- pending_o  output  N  current pending register; a served bit is already cleared.

Behaviour:
- One clock domain: clk. Reset rst is asynchronous and active-high. Every register clears immediately on rst=1, independent of clk.
- Reset values: pending=0, code_o=0, valid_o=0, ptr=0, state=IDLE.
- Capture: each edge, pending <= (pending & ~load_mask) | (en ? req : 0).
  - load_mask is the one-hot of the index loaded this cycle, or 0.
  - Capture is level-sampled and sticky. Repeated assertion of an already-pending bit merges into it; there is no counting.
  - en=0 gates capture only. Already-pending bits continue to drain.
- Pick: combinational, from the registered pending value. The first set bit is searched in order ptr, ptr+1, …, N-1, 0, …, ptr-1.
- State machine, two states:
  - IDLE (valid_o=0): if pending≠0, load code_o=pick, clear that pending bit, set valid_o=1, go to HOLD. Otherwise stay.
  - HOLD (valid_o=1): code_o and valid_o stay stable while ready_i=0.
  - On handshake (valid_o & ready_i), ptr <= code_o+1 mod N.
    - If pending≠0 in the same cycle, load the next pick immediately (back-to-back, one grant per cycle) and stay in HOLD.
    - Otherwise valid_o <= 0 and go to IDLE.
  - The next pick in a handshake cycle uses the current ptr search, excluding the bit being retired. That bit is already cleared from pending.
- Latency: req sampled at edge E0 → valid_o high after edge E1 (2-cycle minimum). Sustained throughput is 1 code per cycle while ready_i=1.
- Boundaries:
  - ptr wraps from N-1 to 0.
  - A req for the index currently held in code_o re-sets its pending bit. That index is served again later, after the rotation.
  - A req arriving in the same cycle as its bit's load re-sets the bit. Capture wins over clear.
  - All N pending with ready_i=1: indices are served ptr, ptr+1, … in N consecutive cycles, no bubbles.
  - rst mid-HOLD: the held code is dropped, valid_o drops asynchronously, and all pending is lost.
  - ready_i while valid_o=0 is ignored.
- All arithmetic is unsigned. ptr is CODE_W bits with natural modulo-N wrap.

Decomposition:
- Shared package enc_pkg:
  - localparam N_DEF=8 and CODE_W_DEF=3.
  - Typedef state_t {IDLE, HOLD}.
  - Function onehot2bin used by both the pick logic and the bench.
- One sub-module, rr_pick: purely combinational.
  - Inputs: pending[N], ptr[CODE_W].
  - Outputs: any, idx[CODE_W], onehot[N].
  - Implemented by rotate, find-first-set, un-rotate.
- Top level holds only registers and the state machine.

Test Plan:
1. Reset, then en=1, req=8'b0000_0100 for one cycle, ready_i=1 → valid_o high 2 edges later with code_o=3'd2 for one cycle. pending_o returns to 0. ptr becomes 3.
2. en=1, req=8'hFF for one cycle, ready_i=1, ptr=3 → codes 3,4,5,6,7,0,1,2 on 8 consecutive cycles with valid_o continuously high, then valid_o=0.
3. Backpressure: pending=8'b0001_0010, ready_i=0 for 5 cycles → code_o=1 held stable, valid_o=1. Raise ready_i → next cycle code_o=4, then idle.
4. en=0 with req=8'hFF for 10 cycles → pending_o=0 and valid_o=0 throughout. Then en=1 with req=8'h80 for one cycle → code_o=7.
5. While code_o=5 is held (ready_i=0), pulse req=8'h20 → pending_o[5]=1. After the handshake, index 5 is served again once earlier-rotated bits are done.
6. Assert rst between edges during HOLD with pending=8'h0F → valid_o, code_o, pending_o go to 0 immediately, before the next clk edge. After release, no output appears without new req.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared definitions for the encoder family: default sizes, FSM states and
// the one-hot to binary helper.
package enc_pkg;

    localparam int unsigned N_DEF      = 8;
    localparam int unsigned CODE_W_DEF = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Binary index of a one-hot word; a zero word yields 0.
    function automatic int unsigned onehot2bin(input logic [31:0] oh);
        int unsigned b;
        b = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (oh[i]) b = b | i;
        end
        return b;
    endfunction

endpackage

// File: rtl/req_rr_encoder_rr_pick.sv
// Round-robin pick: first set bit of pending searched upward from ptr, with wrap.
module rr_pick
    import enc_pkg::*;
#(
    parameter  int unsigned N      = N_DEF,
    localparam int unsigned CODE_W = $clog2(N)
) (
    input  logic [N-1:0]      pending,
    input  logic [CODE_W-1:0] ptr,
    output logic              any,
    output logic [CODE_W-1:0] idx,
    output logic [N-1:0]      onehot
);

    logic [N-1:0] rot;
    logic [N-1:0] first;

    // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate the index back.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            rot[i] = pending[CODE_W'(i) + ptr];
        end
        first  = rot & (~rot + N'(1));
        any    = |pending;
        idx    = CODE_W'(onehot2bin(32'(first))) + ptr;
        onehot = N'(1) << idx;
    end

endmodule

// File: rtl/req_rr_encoder.sv
// Captures request lines into a sticky pending register and serves them one
// at a time, round-robin, as binary codes on a valid/ready interface.
module req_rr_encoder
    import enc_pkg::*;
#(
    parameter  int unsigned N      = N_DEF,
    localparam int unsigned CODE_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N-1:0]      req,
    input  logic              ready_i,
    output logic [CODE_W-1:0] code_o,
    output logic              valid_o,
    output logic [N-1:0]      pending_o
);

    state_t            state, state_n;
    logic [CODE_W-1:0] ptr, ptr_n;
    logic [CODE_W-1:0] code_n;
    logic              valid_n;
    logic [N-1:0]      pending, pending_n;
    logic [N-1:0]      load_mask;
    logic              load;
    logic              pick_any;
    logic [CODE_W-1:0] pick_idx;
    logic [N-1:0]      pick_onehot;

    rr_pick #(.N(N)) u_pick (
        .pending (pending),
        .ptr     (ptr),
        .any     (pick_any),
        .idx     (pick_idx),
        .onehot  (pick_onehot)
    );

    // Next-state and grant logic; the pick always uses the current ptr.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        code_n  = code_o;
        valid_n = valid_o;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    load    = 1'b1;
                    code_n  = pick_idx;
                    valid_n = 1'b1;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (ready_i) begin
                    ptr_n = code_o + CODE_W'(1);
                    if (pick_any) begin
                        load   = 1'b1;
                        code_n = pick_idx;
                    end else begin
                        valid_n = 1'b0;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        load_mask = load ? pick_onehot : '0;
        // Capture is applied after the clear so a same-cycle request re-arms its bit.
        pending_n = (pending & ~load_mask) | (en ? req : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            code_o  <= '0;
            valid_o <= 1'b0;
            pending <= '0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            code_o  <= code_n;
            valid_o <= valid_n;
            pending <= pending_n;
        end
    end

    assign pending_o = pending;

endmodule

// File: tb/tb_req_rr_encoder.sv
// Self-checking bench for req_rr_encoder: directed scenarios plus random
// traffic against a behavioural round-robin model.
module tb_req_rr_encoder;
    import enc_pkg::*;

    localparam int unsigned N = 8;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       ready_i;
    logic [2:0] code_o;
    logic       valid_o;
    logic [7:0] pending_o;

    int unsigned n_checks;
    int unsigned n_fail;

    // Behavioural model state
    logic [7:0]  m_pending;
    int unsigned m_code;
    logic        m_valid;
    int unsigned m_ptr;

    req_rr_encoder #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .ready_i   (ready_i),
        .code_o    (code_o),
        .valid_o   (valid_o),
        .pending_o (pending_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One-hot mask of the first pending index at or after ptr, wrapping; 0 if none.
    function automatic logic [7:0] rr_search(input logic [7:0] p, input int unsigned ptr);
        for (int unsigned k = 0; k < N; k++) begin
            int unsigned i;
            i = (ptr + k) % N;
            if (p[i]) return 8'(1) << i;
        end
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_pending = 8'h00;
        m_code    = 0;
        m_valid   = 1'b0;
        m_ptr     = 0;
    endtask

    // Advance the model by one clock edge given this cycle's inputs.
    task automatic model_step(input logic e, input logic [7:0] r, input logic rd);
        logic        fire;
        logic [7:0]  win;
        int unsigned ptr_next;
        fire     = m_valid && rd;
        ptr_next = fire ? (m_code + 1) % N : m_ptr;
        win      = 8'h00;
        if (!m_valid || fire) win = rr_search(m_pending, m_ptr);
        if (win != 8'h00) begin
            m_code    = onehot2bin(32'(win));
            m_valid   = 1'b1;
            m_pending = m_pending & ~win;
        end else if (fire) begin
            m_valid = 1'b0;
        end
        if (e) m_pending = m_pending | r;
        m_ptr = ptr_next;
    endtask

    task automatic cycle(input logic e, input logic [7:0] r, input logic rd);
        en      = e;
        req     = r;
        ready_i = rd;
        model_step(e, r, rd);
        @(posedge clk);
        #1;
        check("code_o", 32'(code_o), m_code);
        check("valid_o", 32'(valid_o), 32'(m_valid));
        check("pending_o", 32'(pending_o), 32'(m_pending));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic seen5;
        n_checks = 0;
        n_fail   = 0;
        en       = 1'b0;
        req      = 8'h00;
        ready_i  = 1'b0;
        rst      = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_code", 32'(code_o), 0);
        check("rst_valid", 32'(valid_o), 0);
        check("rst_pending", 32'(pending_o), 0);
        rst = 1'b0;

        // Single request: code 2 two edges after capture, then idle with ptr=3
        cycle(1'b1, 8'h04, 1'b1);
        check("t1_no_early_valid", 32'(valid_o), 0);
        cycle(1'b1, 8'h00, 1'b1);
        check("t1_code", 32'(code_o), 2);
        check("t1_valid", 32'(valid_o), 1);
        cycle(1'b1, 8'h00, 1'b1);
        check("t1_idle", 32'(valid_o), 0);
        check("t1_pending", 32'(pending_o), 0);

        // All requests from ptr=3: eight back-to-back grants 3..2
        cycle(1'b1, 8'hFF, 1'b1);
        for (int unsigned k = 0; k < 8; k++) begin
            cycle(1'b1, 8'h00, 1'b1);
            check("t2_code", 32'(code_o), (3 + k) % 8);
            check("t2_valid", 32'(valid_o), 1);
        end
        cycle(1'b1, 8'h00, 1'b1);
        check("t2_done", 32'(valid_o), 0);

        // Backpressure from ptr=0: code 1 held, then 4
        do_reset();
        cycle(1'b1, 8'h12, 1'b0);
        for (int unsigned k = 0; k < 5; k++) begin
            cycle(1'b1, 8'h00, 1'b0);
            check("t3_hold_code", 32'(code_o), 1);
            check("t3_hold_valid", 32'(valid_o), 1);
        end
        cycle(1'b1, 8'h00, 1'b1);
        check("t3_next_code", 32'(code_o), 4);
        cycle(1'b1, 8'h00, 1'b1);
        check("t3_idle", 32'(valid_o), 0);

        // Capture gated off
        for (int unsigned k = 0; k < 10; k++) begin
            cycle(1'b0, 8'hFF, 1'b1);
            check("t4_pending", 32'(pending_o), 0);
            check("t4_valid", 32'(valid_o), 0);
        end
        cycle(1'b1, 8'h80, 1'b1);
        cycle(1'b1, 8'h00, 1'b1);
        check("t4_code", 32'(code_o), 7);
        cycle(1'b1, 8'h00, 1'b1);

        // Re-request of the held index while stalled
        do_reset();
        cycle(1'b1, 8'h20, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        check("t5_held", 32'(code_o), 5);
        cycle(1'b1, 8'h64, 1'b0);
        check("t5_rearm", 32'(pending_o[5]), 1);
        seen5 = 1'b0;
        for (int unsigned k = 0; k < 10; k++) begin
            cycle(1'b0, 8'h00, 1'b1);
            if (valid_o && code_o == 3'd5) seen5 = 1'b1;
        end
        check("t5_reserved", 32'(seen5), 1);

        // Asynchronous reset in the middle of HOLD
        do_reset();
        cycle(1'b1, 8'h0F, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        check("t6_pre_valid", 32'(valid_o), 1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_valid", 32'(valid_o), 0);
        check("t6_async_code", 32'(code_o), 0);
        check("t6_async_pending", 32'(pending_o), 0);
        model_reset();
        #1;
        rst = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            cycle(1'b0, 8'h00, 1'b1);
        end

        // Random traffic
        for (int unsigned k = 0; k < 600; k++) begin
            logic       e;
            logic [7:0] r;
            logic       rd;
            e  = ($urandom_range(0, 3) != 0);
            r  = 8'($urandom) & 8'($urandom);
            rd = ($urandom_range(0, 2) != 0);
            cycle(e, r, rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
